vfd_persist_scanner: RTL and testbench
======================================

Name: vfd_persist_scanner

Overview:
- Parametrised successor to the VFD front end.
- Samples the multiplexed grid/segment outputs of the MCU on a sample tick and keeps a per-cell (grid × segment) brightness level with attack and phosphor-style decay.
- Streams changed levels to the renderer's segment-state memory.
- Sits between the ucom43 port outputs and the VRAM/sprite renderer; generalises grid count, segment count and brightness depth.

Parameters:
- NGRID, 16, number of grid lines.
- NSEG, 24, number of segment/anode lines.
- BW, 4, brightness bits per cell; max level LMAX = 2^BW-1.
- ATTACK, 15, level increment when a cell is lit; result saturates at LMAX.
- DECAY_DIV, 8, decay applied once every DECAY_DIV sweeps.
- CHG_ONLY, 1, 1 = emit only cells whose level changed; 0 = emit every cell every sweep.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rdy  in  1  1 = sample ticks accepted; 0 = ticks ignored.
- sample_tick  in  1  one-cycle strobe requesting a sweep.
- grid  in  NGRID  active-high grid drive.
- seg  in  NSEG  active-high segment drive.
- ovr_clr  in  1  clears the sticky overrun flag.
- out_addr  out  AW  cell index g*NSEG+s, AW = $clog2(NGRID*NSEG).
- out_level  out  BW  new level of the cell.
- out_we  out  1  write strobe for out_addr/out_level.
- busy  out  1  high in CLEAR or SWEEP.
- frame_done  out  1  one-cycle pulse after the last write of a sweep.
- overrun  out  1  sticky: a tick was lost.

Behaviour:
- Reset (asynchronous, active-low, effective immediately, including mid-sweep):
  - All outputs go to 0; pending, decay_cnt and the FSM reset.
  - The FSM enters CLEAR. Level RAM contents are not reset.
- States: CLEAR, IDLE, SWEEP.
- CLEAR:
  - Walks addr 0..N-1 (N = NGRID*NSEG) writing 0 to the RAM.
  - Emits out_we with level 0 for every cell regardless of CHG_ONLY.
  - Then goes to IDLE. No frame_done pulse.
  - Ticks during CLEAR are ignored.
- IDLE:
  - When sample_tick&rdy, or pending: snapshot grid/seg into registers, clear pending, go to SWEEP.
  - The snapshot is held for the whole sweep; input changes mid-sweep are ignored.
- SWEEP:
  - Read-modify-write one cell per cycle, g outer, s inner, addr 0..N-1.
  - Two-stage pipeline: RAM read (1 cycle) then compute/write.
  - out_we for cell k is asserted exactly 2 cycles after its read address is issued.
  - A sweep occupies N+2 cycles; frame_done pulses on the cycle after the final out_we slot.
  - Then go to IDLE, and decay_cnt increments, wrapping at DECAY_DIV-1 → 0.
- Level update for a cell:
  - lit = grid_s[g] & seg_s[s].
  - lit: new = min(old+ATTACK, LMAX), computed in BW+1 bits then saturated.
  - !lit and decay_cnt == DECAY_DIV-1: new = (old==0) ? 0 : old-1.
  - Otherwise: new = old.
- Emission: out_we = 1 when CHG_ONLY==0 or new != old. RAM is always written.
- Tick while busy (SWEEP only, rdy high):
  - Pending clear → set pending; it is serviced on the cycle SWEEP returns to IDLE, so no IDLE dwell.
  - Pending already set → overrun := 1.
- overrun stays set until ovr_clr. If ovr_clr and an overrun event occur in the same cycle, set wins.
- rdy low: no new sweeps start. A sweep in progress completes. Pending is retained.
- DECAY_DIV=1: decay every sweep. ATTACK ≥ LMAX: lit cells go straight to LMAX.

Decomposition:
- Package vfd_pkg: AW derivation function, level saturating add/sub functions, FSM state enum (CLEAR/IDLE/SWEEP), cell-index function g*NSEG+s.
- One sub-module: vfd_level_ram, a simple dual-port RAM (N × BW) with synchronous read, 1-cycle latency, and a write port; no reset on contents.

Test Plan:
- Reset release, defaults: exactly 384 out_we pulses, addr 0..383, level 0; busy high for 386 cycles then 0; frame_done never pulses.
- Single lit cell: grid=16'h0001, seg=24'h000008, one tick → exactly one out_we, addr 3, level 15; frame_done pulses 386 cycles after sweep start.
- Decay: after the above, 7 ticks with seg=0 → no writes for ticks 1–6; the 7th (decay_cnt=7) emits addr 3, level 14. Further decay sweeps step 13, 12, … and stop at 0.
- Saturation/CHG_ONLY: same cell lit on two consecutive sweeps → second sweep emits nothing. With CHG_ONLY=0 every sweep emits 384 writes.
- Tick handling:
  - One tick mid-sweep → next sweep starts the cycle after IDLE is re-entered, overrun=0.
  - Two ticks mid-sweep → overrun=1, held until ovr_clr pulse → 0.
- Reset mid-sweep: assert reset_n=0 at addr 100 → outputs 0 within the same cycle; after release, CLEAR emits 384 zero writes; a subsequent sweep with no lit cells emits nothing.

Source files
------------

// File: rtl/vfd_pkg.sv
// vfd_pkg -- shared types and helpers for the VFD persistence scanner.
//   vfd_state_t   : scanner FSM states (CLEAR / IDLE / SWEEP)
//   vfd_aw        : address width for a given depth (at least 1 bit)
//   vfd_cell_idx  : linear cell index g*NSEG+s, the layout the renderer uses
//   lvl_sat_add   : attack step, saturating at the maximum level
//   lvl_dec       : decay step, floored at zero
package vfd_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } vfd_state_t;

    function automatic int vfd_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int vfd_cell_idx(input int g, input int s, input int nseg);
        return g * nseg + s;
    endfunction

    // Sum is formed in a full int so an ATTACK larger than the level range
    // still saturates instead of wrapping.
    function automatic int lvl_sat_add(input int old_lvl, input int inc, input int lmax);
        int sum;
        sum = old_lvl + inc;
        return (sum > lmax) ? lmax : sum;
    endfunction

    function automatic int lvl_dec(input int old_lvl);
        return (old_lvl == 0) ? 0 : old_lvl - 1;
    endfunction

endpackage

// File: rtl/vfd_level_ram.sv
// vfd_level_ram -- DEPTH x BW simple dual-port level store.
//   clk    : clock
//   we     : write enable, waddr/wdata written on the rising edge
//   raddr  : read address, rdata valid one cycle later
//   rdata  : registered read data
// Contents are not reset; the scanner's CLEAR pass initialises them.
module vfd_level_ram #(
    parameter int DEPTH = 384,
    parameter int AW    = 9,
    parameter int BW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [BW-1:0] rdata
);

    logic [BW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vfd_persist_scanner.sv
// vfd_persist_scanner -- samples the MCU grid/segment drive on a tick and
// keeps a per-cell brightness level with attack and slow decay, streaming
// level updates to the renderer's segment-state memory.
//   clk, reset_n : clock, asynchronous active-low reset
//   rdy          : gate for sample_tick
//   sample_tick  : one-cycle sweep request
//   grid, seg    : active-high grid / segment drive from the MCU
//   ovr_clr      : clears the sticky overrun flag
//   out_addr     : cell index g*NSEG+s
//   out_level    : new level of that cell
//   out_we       : write strobe for out_addr/out_level
//   busy         : CLEAR or SWEEP in progress
//   frame_done   : one-cycle pulse after the last write slot of a sweep
//   overrun      : sticky, a tick was lost
module vfd_persist_scanner
    import vfd_pkg::*;
#(
    parameter  int NGRID     = 16,
    parameter  int NSEG      = 24,
    parameter  int BW        = 4,
    parameter  int ATTACK    = 15,
    parameter  int DECAY_DIV = 8,
    parameter  int CHG_ONLY  = 1,
    localparam int N         = NGRID * NSEG,
    localparam int AW        = vfd_aw(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rdy,
    input  logic             sample_tick,
    input  logic [NGRID-1:0] grid,
    input  logic [NSEG-1:0]  seg,
    input  logic             ovr_clr,
    output logic [AW-1:0]    out_addr,
    output logic [BW-1:0]    out_level,
    output logic             out_we,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam int LMAX = (1 << BW) - 1;
    localparam int CW   = vfd_aw(N + 2);
    localparam int GW   = vfd_aw(NGRID);
    localparam int SW   = vfd_aw(NSEG);
    localparam int DCW  = vfd_aw(DECAY_DIV);

    vfd_state_t       state;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    g_idx;
    logic [SW-1:0]    s_idx;
    logic [NGRID-1:0] grid_s;
    logic [NSEG-1:0]  seg_s;
    logic             pending;
    logic [DCW-1:0]   decay_cnt;

    logic             start;
    logic             tick_busy;
    logic             decay_now;
    logic             issue_p0;
    logic             lit_p0;

    logic             vld_p1;
    logic             clr_p1;
    logic             lit_p1;
    logic [AW-1:0]    addr_p1;
    logic [BW-1:0]    rd_lvl_p1;
    logic [BW-1:0]    new_lvl_p1;
    logic             emit_p1;

    // Pending requests are serviced only while rdy is high; they stay latched otherwise.
    assign start     = (state == ST_IDLE) && rdy && (sample_tick || pending);
    assign tick_busy = (state == ST_SWEEP) && rdy && sample_tick;
    assign decay_now = (decay_cnt == DCW'(DECAY_DIV - 1));

    // busy is low only in IDLE and in the first cycle after reset release,
    // which gives CLEAR the same N+2 cycle shape as a sweep.
    assign issue_p0 = busy && (cnt < CW'(N));
    assign lit_p0   = grid_s[g_idx] & seg_s[s_idx];

    // ---- stage p0 -> p1: RAM read issued, cell attributes registered ----
    vfd_level_ram #(
        .DEPTH (N),
        .AW    (AW),
        .BW    (BW)
    ) u_ram (
        .clk   (clk),
        .we    (vld_p1),
        .waddr (addr_p1),
        .wdata (new_lvl_p1),
        .raddr (AW'(cnt)),
        .rdata (rd_lvl_p1)
    );

    always_ff @(posedge clk) begin
        if (start) begin
            grid_s <= grid;
            seg_s  <= seg;
        end
        addr_p1 <= AW'(cnt);
        lit_p1  <= lit_p0;
        clr_p1  <= (state == ST_CLEAR);
    end

    // ---- stage p1: level update and RAM write-back ----
    always_comb begin
        new_lvl_p1 = rd_lvl_p1;
        if (clr_p1) begin
            new_lvl_p1 = '0;
        end else if (lit_p1) begin
            new_lvl_p1 = BW'(lvl_sat_add(int'(rd_lvl_p1), ATTACK, LMAX));
        end else if (decay_now) begin
            new_lvl_p1 = BW'(lvl_dec(int'(rd_lvl_p1)));
        end
    end

    assign emit_p1 = clr_p1 || (CHG_ONLY == 0) || (new_lvl_p1 != rd_lvl_p1);

    // ---- stage p2: registered output port, plus control FSM ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            g_idx      <= '0;
            s_idx      <= '0;
            pending    <= 1'b0;
            decay_cnt  <= '0;
            vld_p1     <= 1'b0;
            out_we     <= 1'b0;
            out_addr   <= '0;
            out_level  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            vld_p1     <= 1'b0;
            out_we     <= vld_p1 && emit_p1;
            if (vld_p1) begin
                out_addr  <= addr_p1;
                out_level <= new_lvl_p1;
            end

            if (start) begin
                pending <= 1'b0;
            end else if (tick_busy) begin
                pending <= 1'b1;
            end

            // A set event outranks a simultaneous clear.
            if (tick_busy && pending) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                ST_CLEAR, ST_SWEEP: begin
                    if (!busy) begin
                        busy <= 1'b1;
                    end else begin
                        vld_p1 <= issue_p0;
                        if (cnt == CW'(N + 1)) begin
                            cnt   <= '0;
                            g_idx <= '0;
                            s_idx <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                            if (state == ST_SWEEP) begin
                                frame_done <= 1'b1;
                                decay_cnt  <= decay_now ? '0 : decay_cnt + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (issue_p0) begin
                                if (s_idx == SW'(NSEG - 1)) begin
                                    s_idx <= '0;
                                    g_idx <= g_idx + 1'b1;
                                end else begin
                                    s_idx <= s_idx + 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SWEEP;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vfd_persist_scanner.sv
module tb_vfd_persist_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, rdy, sample_tick, ovr_clr;
    logic [15:0] grid;
    logic [23:0] seg;

    logic [8:0]  a_addr;
    logic [3:0]  a_level;
    logic        a_we, a_busy, a_fd, a_ovr;
    logic [2:0]  b_addr;
    logic [2:0]  b_level;
    logic        b_we, b_busy, b_fd, b_ovr;

    // Default build: 16 x 24 cells, 4-bit levels, change-only output.
    vfd_persist_scanner #(
        .NGRID(16), .NSEG(24), .BW(4), .ATTACK(15), .DECAY_DIV(8), .CHG_ONLY(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .sample_tick(sample_tick),
        .grid(grid), .seg(seg), .ovr_clr(ovr_clr),
        .out_addr(a_addr), .out_level(a_level), .out_we(a_we),
        .busy(a_busy), .frame_done(a_fd), .overrun(a_ovr)
    );

    // Small build: 2 x 3 cells, 3-bit levels, ATTACK above LMAX,
    // decay every sweep, every cell emitted every sweep.
    vfd_persist_scanner #(
        .NGRID(2), .NSEG(3), .BW(3), .ATTACK(9), .DECAY_DIV(1), .CHG_ONLY(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .sample_tick(sample_tick),
        .grid(grid[1:0]), .seg(seg[2:0]), .ovr_clr(ovr_clr),
        .out_addr(b_addr), .out_level(b_level), .out_we(b_we),
        .busy(b_busy), .frame_done(b_fd), .overrun(b_ovr)
    );

    // ---------------- output monitor (negedge) ----------------
    int         cyc = 0;
    int         a_total = 0, a_fd_cnt = 0, a_fd_cyc = 0, a_prev_fd_cyc = 0;
    int         a_rise_cyc = 0, a_busy_cyc = 0;
    logic       a_busy_q = 1'b0;
    logic [8:0] a_log_addr [0:4095];
    logic [3:0] a_log_lvl  [0:4095];
    int         a_log_cyc  [0:4095];
    int         b_total = 0, b_sum = 0, b_fd_cnt = 0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        a_busy_q <= a_busy;
        if (a_busy) a_busy_cyc <= a_busy_cyc + 1;
        if (a_busy && !a_busy_q) a_rise_cyc <= cyc;
        if (a_fd) begin
            a_fd_cnt      <= a_fd_cnt + 1;
            a_prev_fd_cyc <= a_fd_cyc;
            a_fd_cyc      <= cyc;
        end
        if (a_we) begin
            a_log_addr[a_total[11:0]] <= a_addr;
            a_log_lvl[a_total[11:0]]  <= a_level;
            a_log_cyc[a_total[11:0]]  <= cyc;
            a_total <= a_total + 1;
        end
        if (b_we) begin
            b_total <= b_total + 1;
            b_sum   <= b_sum + int'(b_level);
        end
        if (b_fd || b_busy) b_fd_cnt <= b_fd_cnt + (b_fd ? 1 : 0);
    end

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string name);
        int k;
        k = 0;
        while (a_fd_cnt < target && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk({name, "_fd_reached"}, (a_fd_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic run_sweep(input logic [15:0] g, input logic [23:0] s, input string name);
        int fd0;
        fd0  = a_fd_cnt;
        grid = g;
        seg  = s;
        pulse_tick();
        wait_fd(fd0 + 1, name);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] g;
        logic [23:0] s;
        int          a_n;
        int          a_fa;
        int          a_fl;
        int          a_la;
        int          a_ll;
        int          b_sum;
    } vec_t;

    vec_t tbl [25];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bt0, bs0, bc0, fd0, errs, k;

        // decay_cnt runs 0..7 per sweep starting at 0 after reset
        tbl[0] = '{16'h0001, 24'h000008, 1, 3, 15, 3, 15, 0};
        for (int i = 1; i <= 6; i++) tbl[i] = '{16'h0001, 24'h000000, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{16'h0001, 24'h000000, 1, 3, 14, 3, 14, 0};
        tbl[8]  = '{16'h0001, 24'h000008, 1, 3, 15, 3, 15, 0};
        tbl[9]  = '{16'h0001, 24'h000008, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{16'h8000, 24'h800000, 1, 383, 15, 383, 15, 0};
        tbl[11] = '{16'h0002, 24'h000001, 1, 24, 15, 24, 15, 7};
        tbl[12] = '{16'h0000, 24'h000000, 0, 0, 0, 0, 0, 6};
        tbl[13] = '{16'h0000, 24'h000000, 0, 0, 0, 0, 0, 5};
        tbl[14] = '{16'h0000, 24'h000000, 0, 0, 0, 0, 0, 4};
        tbl[15] = '{16'h0000, 24'h000000, 3, 3, 14, 383, 14, 3};
        tbl[16] = '{16'h0003, 24'h000005, 4, 0, 15, 26, 15, 28};
        tbl[17] = '{16'h0000, 24'h000000, 0, 0, 0, 0, 0, 24};
        for (int j = 0; j < 5; j++) tbl[18 + j] = '{16'h0000, 24'h000000, 0, 0, 0, 0, 0, 20 - 4 * j};
        tbl[23] = '{16'h0000, 24'h000000, 6, 0, 14, 383, 13, 0};
        tbl[24] = '{16'h0000, 24'h000000, 0, 0, 0, 0, 0, 0};

        reset_n = 1'b0; rdy = 1'b1; sample_tick = 1'b0; ovr_clr = 1'b0;
        grid = '0; seg = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_we", a_we, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_frame_done", a_fd, 0);
        chk("rst_overrun", a_ovr, 0);
        chk("rst_addr_level", {a_addr, a_level}, 0);
        chk("rst_b_busy", b_busy, 0);

        // ---- CLEAR after reset release; a tick during CLEAR is ignored ----
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(posedge clk);
        pulse_tick();
        repeat (400) @(posedge clk);
        #1;
        chk("clr_writes", a_total, 384);
        errs = 0;
        for (int i = 0; i < 384; i++)
            if (a_log_addr[i] != 9'(i) || a_log_lvl[i] != 4'd0) errs++;
        chk("clr_seq_errors", errs, 0);
        chk("clr_busy_cycles", a_busy_cyc, 386);
        chk("clr_no_frame_done", a_fd_cnt, 0);
        chk("clr_busy_after", a_busy, 0);
        chk("b_clr_plus_sweep_writes", b_total, 12);
        chk("b_clr_sum", b_sum, 0);

        // ---- table-driven sweeps ----
        for (int i = 0; i < 25; i++) begin
            base = a_total; bt0 = b_total; bs0 = b_sum; bc0 = a_busy_cyc;
            run_sweep(tbl[i].g, tbl[i].s, $sformatf("v%0d", i));
            chk($sformatf("v%0d_a_writes", i), a_total - base, tbl[i].a_n);
            if (tbl[i].a_n > 0 && a_total > base) begin
                chk($sformatf("v%0d_first_addr", i), a_log_addr[base[11:0]], tbl[i].a_fa);
                chk($sformatf("v%0d_first_level", i), a_log_lvl[base[11:0]], tbl[i].a_fl);
                k = a_total - 1;
                chk($sformatf("v%0d_last_addr", i), a_log_addr[k[11:0]], tbl[i].a_la);
                chk($sformatf("v%0d_last_level", i), a_log_lvl[k[11:0]], tbl[i].a_ll);
                chk($sformatf("v%0d_we_latency", i), a_log_cyc[base[11:0]] - a_rise_cyc, tbl[i].a_fa + 2);
            end
            chk($sformatf("v%0d_busy_cycles", i), a_busy_cyc - bc0, 386);
            chk($sformatf("v%0d_fd_delay", i), a_fd_cyc - a_rise_cyc, 386);
            chk($sformatf("v%0d_b_writes", i), b_total - bt0, 6);
            chk($sformatf("v%0d_b_sum", i), b_sum - bs0, tbl[i].b_sum);
        end

        // ---- one tick mid-sweep: back-to-back sweep, no overrun ----
        grid = '0; seg = '0;
        fd0 = a_fd_cnt; base = a_total;
        pulse_tick();
        repeat (100) @(posedge clk);
        pulse_tick();
        wait_fd(fd0 + 2, "pend");
        chk("pend_restart_gap", a_rise_cyc - a_prev_fd_cyc, 1);
        chk("pend_overrun", a_ovr, 0);
        chk("pend_no_writes", a_total - base, 0);
        repeat (5) @(posedge clk);

        // ---- two ticks mid-sweep: overrun, set beats clear, then clear ----
        fd0 = a_fd_cnt;
        pulse_tick();
        repeat (50) @(posedge clk);
        pulse_tick();
        repeat (50) @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b1; ovr_clr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0; ovr_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("ovr_set_wins", a_ovr, 1);
        wait_fd(fd0 + 2, "ovr");
        repeat (420) @(posedge clk);
        #1;
        chk("ovr_sweeps", a_fd_cnt - fd0, 2);
        chk("ovr_held", a_ovr, 1);
        chk("b_no_overrun", b_ovr, 0);
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        #1;
        chk("ovr_cleared", a_ovr, 0);

        // ---- rdy low: tick ignored ----
        rdy = 1'b0;
        pulse_tick();
        repeat (20) @(posedge clk);
        #1;
        chk("rdy_low_idle", a_busy, 0);
        rdy = 1'b1;
        repeat (2) @(posedge clk);

        // ---- reset mid-sweep at addr 100 ----
        grid = 16'hFFFF; seg = 24'hFFFFFF;
        pulse_tick();
        k = 0;
        while (!(a_we && a_addr == 9'd100) && k < 600) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mid_reach_addr100", (a_we && a_addr == 9'd100) ? 1 : 0, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", a_we, 0);
        chk("mid_rst_busy_fd", {a_busy, a_fd}, 0);
        chk("mid_rst_addr_level", {a_addr, a_level}, 0);
        base = a_total; fd0 = a_fd_cnt;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        grid = '0; seg = '0;
        repeat (400) @(posedge clk);
        #1;
        chk("mid_clr_writes", a_total - base, 384);
        errs = 0;
        for (int i = 0; i < 384; i++) begin
            k = base + i;
            if (a_log_addr[k[11:0]] != 9'(i) || a_log_lvl[k[11:0]] != 4'd0) errs++;
        end
        chk("mid_clr_seq_errors", errs, 0);
        chk("mid_clr_no_fd", a_fd_cnt - fd0, 0);
        base = a_total;
        run_sweep(16'h0000, 24'h000000, "post");
        chk("post_no_writes", a_total - base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
